// File: rtl/matrix_multiplier_nxn.sv
// Streamed N x N single-precision matrix multiplier.
// Operands A then B arrive row-major over a valid/ready stream and are held in
// register arrays. One shared float multiplier and one shared float adder are
// walked through the i/j/k loops. Each C element is streamed out as soon as its
// dot product is complete. The sum order is fixed left to right.

module single_multiplier (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic        a_stb,
    output logic        a_ack,
    input  logic [31:0] b,
    input  logic        b_stb,
    output logic        b_ack,
    output logic [31:0] z,
    output logic        z_stb,
    input  logic        z_ack
);
    logic [31:0] a_r, b_r, z_r;
    logic        got_a_r, got_b_r, a_ack_r, b_ack_r, z_stb_r;

    // Round-to-nearest-even product; subnormals are flushed to signed zero.
    function automatic logic [31:0] fmul(input logic [31:0] x, input logic [31:0] y);
        logic               s;
        logic [7:0]         ex, ey;
        logic [47:0]        prod;
        logic [22:0]        m;
        logic               g, st;
        logic [23:0]        mr;
        logic signed [10:0] e;
        s    = x[31] ^ y[31];
        ex   = x[30:23];
        ey   = y[30:23];
        prod = 48'd0;
        m    = 23'd0;
        g    = 1'b0;
        st   = 1'b0;
        mr   = 24'd0;
        e    = 11'sd0;
        if ((ex == 8'hFF && x[22:0] != 23'd0) || (ey == 8'hFF && y[22:0] != 23'd0)) begin
            fmul = 32'h7FC00000;
        end else if (ex == 8'hFF || ey == 8'hFF) begin
            if (ex == 8'd0 || ey == 8'd0) begin
                fmul = 32'h7FC00000;
            end else begin
                fmul = {s, 8'hFF, 23'd0};
            end
        end else if (ex == 8'd0 || ey == 8'd0) begin
            fmul = {s, 31'd0};
        end else begin
            prod = {24'd0, 1'b1, x[22:0]} * {24'd0, 1'b1, y[22:0]};
            e    = $signed({3'b000, ex}) + $signed({3'b000, ey}) - 11'sd127;
            if (prod[47]) begin
                m  = prod[46:24];
                g  = prod[23];
                st = |prod[22:0];
                e  = e + 11'sd1;
            end else begin
                m  = prod[45:23];
                g  = prod[22];
                st = |prod[21:0];
            end
            mr = {1'b0, m} + {23'd0, g & (st | m[0])};
            if (mr[23]) begin
                e = e + 11'sd1;
            end else begin
                e = e;
            end
            if (e >= 11'sd255) begin
                fmul = {s, 8'hFF, 23'd0};
            end else if (e <= 11'sd0) begin
                fmul = {s, 31'd0};
            end else begin
                fmul = {s, e[7:0], mr[22:0]};
            end
        end
    endfunction

    // Collect both operands, compute once, then hold the product until acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_r     <= 32'd0;
            b_r     <= 32'd0;
            z_r     <= 32'd0;
            got_a_r <= 1'b0;
            got_b_r <= 1'b0;
            a_ack_r <= 1'b0;
            b_ack_r <= 1'b0;
            z_stb_r <= 1'b0;
        end else begin
            a_ack_r <= 1'b0;
            b_ack_r <= 1'b0;
            if (z_stb_r) begin
                if (z_ack) begin
                    z_stb_r <= 1'b0;
                    got_a_r <= 1'b0;
                    got_b_r <= 1'b0;
                end
            end else if (got_a_r && got_b_r) begin
                z_r     <= fmul(a_r, b_r);
                z_stb_r <= 1'b1;
            end else begin
                if (a_stb && !got_a_r) begin
                    a_r     <= a;
                    got_a_r <= 1'b1;
                    a_ack_r <= 1'b1;
                end
                if (b_stb && !got_b_r) begin
                    b_r     <= b;
                    got_b_r <= 1'b1;
                    b_ack_r <= 1'b1;
                end
            end
        end
    end

    assign a_ack = a_ack_r;
    assign b_ack = b_ack_r;
    assign z     = z_r;
    assign z_stb = z_stb_r;
endmodule

module adder (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [31:0] number1,
    input  logic [31:0] number2,
    output logic [31:0] result,
    output logic        result_ready,
    input  logic        result_ack
);
    logic [31:0] result_r;
    logic        ready_r;

    // Round-to-nearest-even sum; subnormal inputs and results are flushed to zero.
    function automatic logic [31:0] fadd(input logic [31:0] x, input logic [31:0] y);
        logic [7:0]        ex, ey, el, es, d;
        logic              sl, ss, g, st;
        logic [22:0]       fl, fs, m;
        logic [26:0]       ml, ms, msh;
        logic [27:0]       sum;
        logic [23:0]       mr;
        logic signed [9:0] e;
        ex = x[30:23];
        ey = y[30:23];
        el = 8'd0; es = 8'd0; d = 8'd0;
        sl = 1'b0; ss = 1'b0; g = 1'b0; st = 1'b0;
        fl = 23'd0; fs = 23'd0; m = 23'd0;
        ml = 27'd0; ms = 27'd0; msh = 27'd0;
        sum = 28'd0;
        mr = 24'd0;
        e = 10'sd0;
        if ((ex == 8'hFF && x[22:0] != 23'd0) || (ey == 8'hFF && y[22:0] != 23'd0)) begin
            fadd = 32'h7FC00000;
        end else if (ex == 8'hFF && ey == 8'hFF) begin
            fadd = (x[31] != y[31]) ? 32'h7FC00000 : x;
        end else if (ex == 8'hFF) begin
            fadd = x;
        end else if (ey == 8'hFF) begin
            fadd = y;
        end else if (ex == 8'd0 && ey == 8'd0) begin
            fadd = {x[31] & y[31], 31'd0};
        end else if (ex == 8'd0) begin
            fadd = y;
        end else if (ey == 8'd0) begin
            fadd = x;
        end else begin
            if ({ex, x[22:0]} >= {ey, y[22:0]}) begin
                sl = x[31]; el = ex; fl = x[22:0];
                ss = y[31]; es = ey; fs = y[22:0];
            end else begin
                sl = y[31]; el = ey; fl = y[22:0];
                ss = x[31]; es = ex; fs = x[22:0];
            end
            d  = el - es;
            ml = {1'b1, fl, 3'b000};
            ms = {1'b1, fs, 3'b000};
            if (d >= 8'd27) begin
                msh = 27'd1;
            end else begin
                msh = ms >> d;
                if ((ms << (8'd27 - d)) != 27'd0) begin
                    msh[0] = 1'b1;
                end else begin
                    msh[0] = msh[0];
                end
            end
            e = $signed({2'b00, el});
            if (sl == ss) begin
                sum = {1'b0, ml} + {1'b0, msh};
            end else begin
                sum = {1'b0, ml} - {1'b0, msh};
            end
            if (sum == 28'd0) begin
                fadd = 32'd0;
            end else begin
                if (sum[27]) begin
                    sum = {1'b0, sum[27:2], sum[1] | sum[0]};
                    e   = e + 10'sd1;
                end else begin
                    sum = sum;
                end
                for (int n = 0; n < 26; n++) begin
                    if (!sum[26]) begin
                        sum = sum << 1;
                        e   = e - 10'sd1;
                    end else begin
                        sum = sum;
                    end
                end
                m  = sum[25:3];
                g  = sum[2];
                st = sum[1] | sum[0];
                mr = {1'b0, m} + {23'd0, g & (st | m[0])};
                if (mr[23]) begin
                    e = e + 10'sd1;
                end else begin
                    e = e;
                end
                if (e >= 10'sd255) begin
                    fadd = {sl, 8'hFF, 23'd0};
                end else if (e <= 10'sd0) begin
                    fadd = {sl, 31'd0};
                end else begin
                    fadd = {sl, e[7:0], mr[22:0]};
                end
            end
        end
    endfunction

    // Register the sum on load and hold it ready until acknowledged.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result_r <= 32'd0;
            ready_r  <= 1'b0;
        end else if (load) begin
            result_r <= fadd(number1, number2);
            ready_r  <= 1'b1;
        end else if (ready_r && result_ack) begin
            ready_r  <= 1'b0;
        end
    end

    assign result       = result_r;
    assign result_ready = ready_r;
endmodule

module matrix_multiplier_nxn #(
    parameter int N     = 2,
    parameter int IDX_W = 3
) (
    input  logic        input_Clk,
    input  logic        input_Reset,
    input  logic        input_Start,
    input  logic [31:0] input_Data,
    input  logic        input_Data_Valid,
    output logic        output_Data_Ready,
    output logic [31:0] output_C,
    output logic        output_C_Valid,
    input  logic        input_C_Ready,
    output logic        output_Busy,
    output logic        output_Done
);
    localparam int NN = N * N;
    localparam int AW = (NN > 1) ? $clog2(NN) : 1;
    localparam int CW = $clog2(2 * NN + 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD     = 3'd1,
        MUL_REQ  = 3'd2,
        MUL_WAIT = 3'd3,
        ADD_REQ  = 3'd4,
        ADD_WAIT = 3'd5,
        NEXT     = 3'd6,
        OUT      = 3'd7
    } state_t;

    state_t              state_r, next_state_s;
    logic [31:0]         a_mem [0:NN-1];
    logic [31:0]         b_mem [0:NN-1];
    logic [CW-1:0]       cnt_r;
    logic [IDX_W-1:0]    i_r, j_r, k_r;
    logic [31:0]         acc_r, p_r, c_r;
    logic                a_seen_r, b_seen_r;
    logic                ready_r, c_valid_r, busy_r, done_r;
    logic                load_xfer_s, last_word_s, out_xfer_s, last_elem_s, k_last_s;
    logic [AW-1:0]       wr_a_s, wr_b_s, rd_a_s, rd_b_s;
    logic                mul_a_stb_s, mul_b_stb_s, mul_a_ack_s, mul_b_ack_s;
    logic                mul_z_stb_s, mul_z_ack_s;
    logic [31:0]         mul_z_s;
    logic                add_load_s, add_ready_s, add_ack_s;
    logic [31:0]         add_result_s;

    assign load_xfer_s = ready_r & input_Data_Valid;
    assign last_word_s = (cnt_r == CW'(2 * NN - 1));
    assign out_xfer_s  = c_valid_r & input_C_Ready;
    assign last_elem_s = (i_r == IDX_W'(N - 1)) && (j_r == IDX_W'(N - 1));
    assign k_last_s    = (k_r == IDX_W'(N - 1));
    assign wr_a_s      = AW'(cnt_r);
    assign wr_b_s      = AW'(cnt_r - CW'(NN));
    assign rd_a_s      = AW'(32'(i_r) * N + 32'(k_r));
    assign rd_b_s      = AW'(32'(k_r) * N + 32'(j_r));

    single_multiplier u_mul (
        .clk   (input_Clk),
        .rst   (input_Reset),
        .a     (a_mem[rd_a_s]),
        .a_stb (mul_a_stb_s),
        .a_ack (mul_a_ack_s),
        .b     (b_mem[rd_b_s]),
        .b_stb (mul_b_stb_s),
        .b_ack (mul_b_ack_s),
        .z     (mul_z_s),
        .z_stb (mul_z_stb_s),
        .z_ack (mul_z_ack_s)
    );

    adder u_add (
        .clk          (input_Clk),
        .rst          (input_Reset),
        .load         (add_load_s),
        .number1      (acc_r),
        .number2      (p_r),
        .result       (add_result_s),
        .result_ready (add_ready_s),
        .result_ack   (add_ack_s)
    );

    // State register.
    always_ff @(posedge input_Clk or posedge input_Reset) begin
        if (input_Reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode and handshake strobes to the shared float units.
    always_comb begin
        next_state_s = state_r;
        mul_a_stb_s  = 1'b0;
        mul_b_stb_s  = 1'b0;
        mul_z_ack_s  = 1'b0;
        add_load_s   = 1'b0;
        add_ack_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (input_Start) next_state_s = LOAD;
                else             next_state_s = IDLE;
            end
            LOAD: begin
                if (load_xfer_s && last_word_s) next_state_s = MUL_REQ;
                else                            next_state_s = LOAD;
            end
            MUL_REQ: begin
                mul_a_stb_s = 1'b1;
                mul_b_stb_s = 1'b1;
                if ((a_seen_r | mul_a_ack_s) && (b_seen_r | mul_b_ack_s)) next_state_s = MUL_WAIT;
                else                                                      next_state_s = MUL_REQ;
            end
            MUL_WAIT: begin
                mul_z_ack_s = mul_z_stb_s;
                if (mul_z_stb_s) next_state_s = (k_r == '0) ? NEXT : ADD_REQ;
                else             next_state_s = MUL_WAIT;
            end
            ADD_REQ: begin
                add_load_s   = 1'b1;
                next_state_s = ADD_WAIT;
            end
            ADD_WAIT: begin
                add_ack_s = add_ready_s;
                if (add_ready_s) next_state_s = NEXT;
                else             next_state_s = ADD_WAIT;
            end
            NEXT: begin
                if (k_last_s) next_state_s = OUT;
                else          next_state_s = MUL_REQ;
            end
            OUT: begin
                if (out_xfer_s) next_state_s = last_elem_s ? IDLE : MUL_REQ;
                else            next_state_s = OUT;
            end
            default: next_state_s = IDLE;
        endcase
    end

    // Loop counters, accumulator and registered stream outputs.
    always_ff @(posedge input_Clk or posedge input_Reset) begin
        if (input_Reset) begin
            cnt_r     <= '0;
            i_r       <= '0;
            j_r       <= '0;
            k_r       <= '0;
            acc_r     <= 32'd0;
            p_r       <= 32'd0;
            c_r       <= 32'd0;
            a_seen_r  <= 1'b0;
            b_seen_r  <= 1'b0;
            ready_r   <= 1'b0;
            c_valid_r <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            ready_r   <= (next_state_s == LOAD);
            c_valid_r <= (next_state_s == OUT);
            busy_r    <= (next_state_s != IDLE);
            done_r    <= (state_r == OUT) && out_xfer_s && last_elem_s;
            if (state_r == IDLE && input_Start) begin
                cnt_r <= '0;
            end
            if (state_r == LOAD && load_xfer_s) begin
                cnt_r <= cnt_r + CW'(1);
                if (last_word_s) begin
                    i_r <= '0;
                    j_r <= '0;
                    k_r <= '0;
                end
            end
            if (state_r == MUL_REQ) begin
                if (next_state_s == MUL_WAIT) begin
                    a_seen_r <= 1'b0;
                    b_seen_r <= 1'b0;
                end else begin
                    a_seen_r <= a_seen_r | mul_a_ack_s;
                    b_seen_r <= b_seen_r | mul_b_ack_s;
                end
            end
            if (state_r == MUL_WAIT && mul_z_stb_s) begin
                p_r <= mul_z_s;
                if (k_r == '0) acc_r <= mul_z_s;
            end
            if (state_r == ADD_WAIT && add_ready_s) begin
                acc_r <= add_result_s;
            end
            if (state_r == NEXT) begin
                if (k_last_s) c_r <= acc_r;
                else          k_r <= k_r + IDX_W'(1);
            end
            if (state_r == OUT && out_xfer_s) begin
                k_r <= '0;
                if (j_r == IDX_W'(N - 1)) begin
                    j_r <= '0;
                    i_r <= last_elem_s ? '0 : i_r + IDX_W'(1);
                end else begin
                    j_r <= j_r + IDX_W'(1);
                end
            end
        end
    end

    // Operand storage; contents after reset are don't-care.
    always_ff @(posedge input_Clk) begin
        if (state_r == LOAD && load_xfer_s) begin
            if (cnt_r < CW'(NN)) a_mem[wr_a_s] <= input_Data;
            else                 b_mem[wr_b_s] <= input_Data;
        end
    end

    assign output_Data_Ready = ready_r;
    assign output_C          = c_r;
    assign output_C_Valid    = c_valid_r;
    assign output_Busy       = busy_r;
    assign output_Done       = done_r;
endmodule

// File: tb/tb_matrix_multiplier_nxn.sv
// Directed bench for matrix_multiplier_nxn: one N=2 and one N=3 instance share
// the operand stream and reset; each scenario task drives a job and checks it.

module tb_matrix_multiplier_nxn;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start2 = 1'b0, start3 = 1'b0;
    logic [31:0] data = 32'd0;
    logic        dvalid = 1'b0;
    logic        c_ready = 1'b0;
    logic        rdy2, cv2, busy2, done2, rdy3, cv3, busy3, done3;
    logic [31:0] c2, c3;
    int          errors = 0;
    int          checks = 0;
    int          mul_hs = 0;
    int          add_ld = 0;

    always #5 clk = ~clk;

    matrix_multiplier_nxn #(.N(2), .IDX_W(3)) dut2 (
        .input_Clk(clk), .input_Reset(rst), .input_Start(start2),
        .input_Data(data), .input_Data_Valid(dvalid), .output_Data_Ready(rdy2),
        .output_C(c2), .output_C_Valid(cv2), .input_C_Ready(c_ready),
        .output_Busy(busy2), .output_Done(done2)
    );

    matrix_multiplier_nxn #(.N(3), .IDX_W(3)) dut3 (
        .input_Clk(clk), .input_Reset(rst), .input_Start(start3),
        .input_Data(data), .input_Data_Valid(dvalid), .output_Data_Ready(rdy3),
        .output_C(c3), .output_C_Valid(cv3), .input_C_Ready(c_ready),
        .output_Busy(busy3), .output_Done(done3)
    );

    // Count multiplier result handshakes and adder loads of the N=3 instance.
    always @(posedge clk) begin
        if (dut3.mul_z_stb_s && dut3.mul_z_ack_s) mul_hs <= mul_hs + 1;
        if (dut3.add_load_s) add_ld <= add_ld + 1;
    end

    function automatic logic get_rdy(input int w);  return (w == 3) ? rdy3 : rdy2;  endfunction
    function automatic logic get_cv(input int w);   return (w == 3) ? cv3 : cv2;    endfunction
    function automatic logic get_busy(input int w); return (w == 3) ? busy3 : busy2; endfunction
    function automatic logic get_done(input int w); return (w == 3) ? done3 : done2; endfunction
    function automatic logic [31:0] get_c(input int w); return (w == 3) ? c3 : c2; endfunction

    task automatic start_job(input int w);
        @(negedge clk);
        if (w == 3) start3 = 1'b1; else start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        start3 = 1'b0;
    endtask

    task automatic load_words(input int w, input logic [31:0] words[$], input bit toggle);
        int   idx = 0;
        int   cyc = 0;
        logic r;
        while (idx < words.size() && cyc < 2000) begin
            r      = get_rdy(w);
            dvalid = toggle ? ((cyc % 2) == 0) : 1'b1;
            data   = words[idx];
            if (dvalid && r) idx++;
            cyc++;
            @(negedge clk);
        end
        dvalid = 1'b0;
        checks++;
        if (idx != words.size()) begin
            errors++;
            $display("FAIL load_count: got %0d words accepted, expected %0d", idx, words.size());
        end
        checks++;
        if (get_rdy(w) !== 1'b0) begin
            errors++;
            $display("FAIL ready_drop: got %b, expected 0", get_rdy(w));
        end
    endtask

    task automatic collect(input int w, input logic [31:0] exp_q[$], input bit stall);
        int          idx = 0;
        int          cyc = 0;
        int          unstable;
        bit          stalled = 1'b0;
        logic [31:0] held;
        c_ready = 1'b1;
        while (idx < exp_q.size() && cyc < 5000) begin
            if (get_cv(w)) begin
                if (stall && !stalled) begin
                    held     = get_c(w);
                    c_ready  = 1'b0;
                    unstable = 0;
                    repeat (20) begin
                        @(negedge clk);
                        if (!get_cv(w) || get_c(w) !== held) unstable++;
                    end
                    checks++;
                    if (unstable != 0) begin
                        errors++;
                        $display("FAIL hold_stable: got %0d unstable cycles, expected 0", unstable);
                    end
                    stalled = 1'b1;
                    c_ready = 1'b1;
                end
                checks++;
                if (get_c(w) !== exp_q[idx]) begin
                    errors++;
                    $display("FAIL c_elem[%0d]: got %h, expected %h", idx, get_c(w), exp_q[idx]);
                end
                idx++;
            end
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (idx != exp_q.size()) begin
            errors++;
            $display("FAIL out_count: got %0d results, expected %0d", idx, exp_q.size());
        end
        checks++;
        if ({get_done(w), get_cv(w), get_busy(w)} !== 3'b100) begin
            errors++;
            $display("FAIL done_pulse: got done/valid/busy=%b%b%b, expected 100", get_done(w), get_cv(w), get_busy(w));
        end
        @(negedge clk);
        checks++;
        if ({get_done(w), get_cv(w)} !== 2'b00) begin
            errors++;
            $display("FAIL done_single: got done/valid=%b%b, expected 00", get_done(w), get_cv(w));
        end
    endtask

    task automatic run_job(input int w, input logic [31:0] ops[$], input logic [31:0] exp_q[$],
                           input bit toggle, input bit stall);
        start_job(w);
        load_words(w, ops, toggle);
        collect(w, exp_q, stall);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if ({c2, cv2, rdy2, busy2, done2} !== 36'd0) begin
            errors++;
            $display("FAIL reset_n2: got %h, expected 0", {c2, cv2, rdy2, busy2, done2});
        end
        checks++;
        if ({c3, cv3, rdy3, busy3, done3} !== 36'd0) begin
            errors++;
            $display("FAIL reset_n3: got %h, expected 0", {c3, cv3, rdy3, busy3, done3});
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_identity();
        logic [31:0] ops[$] = '{32'h3F800000, 32'h00000000, 32'h00000000, 32'h3F800000,
                                32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        logic [31:0] ex[$]  = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        run_job(2, ops, ex, 1'b0, 1'b0);
    endtask

    task automatic test_square();
        logic [31:0] ops[$] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        logic [31:0] ex[$]  = '{32'h40E00000, 32'h41200000, 32'h41700000, 32'h41B00000};
        run_job(2, ops, ex, 1'b0, 1'b0);
    endtask

    task automatic test_n3();
        logic [31:0] ops[$];
        logic [31:0] ex[$];
        int          m0, a0;
        for (int n = 0; n < 18; n++) ops.push_back(32'h40000000);
        for (int n = 0; n < 9; n++)  ex.push_back(32'h41400000);
        m0 = mul_hs;
        a0 = add_ld;
        run_job(3, ops, ex, 1'b0, 1'b0);
        checks++;
        if (mul_hs - m0 != 27) begin
            errors++;
            $display("FAIL mul_count: got %0d, expected 27", mul_hs - m0);
        end
        checks++;
        if (add_ld - a0 != 18) begin
            errors++;
            $display("FAIL add_count: got %0d, expected 18", add_ld - a0);
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] ops[$] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        logic [31:0] ex[$]  = '{32'h40E00000, 32'h41200000, 32'h41700000, 32'h41B00000};
        run_job(2, ops, ex, 1'b1, 1'b1);
    endtask

    task automatic test_start_ignored();
        logic [31:0] ops[$] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        logic [31:0] ex[$]  = '{32'h40E00000, 32'h41200000, 32'h41700000, 32'h41B00000};
        int          cyc = 0;
        start_job(2);
        load_words(2, ops, 1'b0);
        while (dut2.state_r != 3'd3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (dut2.state_r != 3'd3) begin
            errors++;
            $display("FAIL reach_mul_wait: got state %0d, expected 3", dut2.state_r);
        end
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        collect(2, ex, 1'b0);
    endtask

    task automatic test_reset_abort();
        logic [31:0] ops[$] = '{32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000,
                                32'h3F800000, 32'h40000000, 32'h40400000, 32'h40800000};
        logic [31:0] ex[$]  = '{32'h40E00000, 32'h41200000, 32'h41700000, 32'h41B00000};
        int          cyc = 0;
        int          bad = 0;
        start_job(2);
        load_words(2, ops, 1'b0);
        while (dut2.state_r != 3'd5 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        checks++;
        if (dut2.state_r != 3'd5) begin
            errors++;
            $display("FAIL reach_add_wait: got state %0d, expected 5", dut2.state_r);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({c2, cv2, rdy2, busy2, done2} !== 36'd0) begin
            errors++;
            $display("FAIL abort_outputs: got %h, expected 0", {c2, cv2, rdy2, busy2, done2});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rdy2 !== 1'b0 || busy2 !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL idle_after_abort: got %0d cycles ready/busy, expected 0", bad);
        end
        run_job(2, ops, ex, 1'b0, 1'b0);
    endtask

    // Bound the whole run in case a handshake never completes.
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    // Scenario sequence and summary.
    initial begin
        test_reset();
        test_identity();
        test_square();
        test_n3();
        test_backpressure();
        test_start_ignored();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
